// File: rtl/rom_fetch.sv
// rom_fetch: initiator side of the byte-wide ROM read port.
// Accepts an aligned word fetch from the core, issues four toggle-triggered
// byte reads, assembles the 32-bit word and hands it over with valid/ready.
// Optional macro ROM_PREFETCH_EN adds a one-word sequential prefetch buffer
// (fetches base+4 after each consumed word). Undefined by default.
module rom_fetch #(
    parameter int WAIT_CYCLES = 1,    // edges from trigger toggle to rom_data sample (1..15)
    parameter bit BIG_ENDIAN  = 1'b0  // 1: byte at base+0 lands in [31:24]
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_addr,
    output logic [31:0] rom_addr,
    output logic        rom_trigger,
    input  logic [7:0]  rom_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q;
    logic [31:0] acc_q;
    logic [31:0] merged;
    logic [31:0] req_base;
    logic [1:0]  k_q;
    logic [1:0]  lane;
    logic [3:0]  cnt_q;
    logic        accept;
    logic        capture;
    logic        last;
    logic        consume;

    assign req_base = req_addr & 32'hFFFF_FFFC;
    assign capture  = (state_q == WAIT) && (cnt_q == 4'd1);
    assign last     = (k_q == 2'd3);
    assign consume  = (state_q == DONE) && instr_valid && instr_ready;
    assign lane     = BIG_ENDIAN ? (2'd3 - k_q) : k_q;

`ifdef ROM_PREFETCH_EN
    logic        pf_active_q;   // current ROM sequence belongs to the prefetch buffer
    logic        pf_valid_q;    // buffer holds a complete word
    logic        redir_q;       // demand miss waiting for the current byte to finish
    logic [31:0] pf_addr_q;
    logic [31:0] pf_data_q;
    logic [31:0] redir_base_q;
    logic [31:0] tgt_base;
    logic        hit;
    logic        steal;
    logic        redir_eff;
    logic        pf_own;

    assign req_ready = ((state_q == IDLE) || pf_active_q) && !flush;
    assign accept    = req_valid && req_ready;
    assign hit       = (state_q == IDLE) && pf_valid_q && (pf_addr_q == req_base);
    // A demand request arriving while the prefetch sequence is running
    assign steal     = accept && pf_active_q;
    assign redir_eff = redir_q || (steal && (req_base != base_q));
    assign tgt_base  = redir_q ? redir_base_q : req_base;
    assign pf_own    = pf_active_q && !steal;
`else
    assign req_ready = (state_q == IDLE) && !flush;
    assign accept    = req_valid && req_ready;
`endif

    // Current word with the incoming ROM byte dropped into its lane
    always_comb begin
        merged = acc_q;
        merged[8*lane +: 8] = rom_data;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ROM_PREFETCH_EN
                    if (accept) state_d = hit ? DONE : ISSUE;
`else
                    if (accept) state_d = ISSUE;
`endif
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (capture) begin
`ifdef ROM_PREFETCH_EN
                        if (redir_eff)   state_d = ISSUE;
                        else if (last)   state_d = pf_own ? IDLE : DONE;
                        else             state_d = ISSUE;
`else
                        state_d = last ? DONE : ISSUE;
`endif
                    end
                end
                DONE: begin
`ifdef ROM_PREFETCH_EN
                    if (consume) state_d = ISSUE;
`else
                    if (consume) state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Fetch datapath: ROM address/trigger, byte assembly and output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            acc_q       <= '0;
            k_q         <= 2'd0;
            cnt_q       <= 4'd0;
            rom_addr    <= '0;
            rom_trigger <= 1'b0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_addr  <= '0;
        end else if (flush) begin
            // partial bytes are dropped; trigger level is left where it is
            instr_valid <= 1'b0;
            k_q         <= 2'd0;
            cnt_q       <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        base_q <= req_base;
                        k_q    <= 2'd0;
                        acc_q  <= '0;
`ifdef ROM_PREFETCH_EN
                        if (hit) begin
                            instr_data <= pf_data_q;
                            instr_addr <= pf_addr_q;
                        end
`endif
                    end
                end
                ISSUE: begin
                    rom_addr    <= base_q + {30'd0, k_q};
                    rom_trigger <= ~rom_trigger;
                    cnt_q       <= 4'(WAIT_CYCLES);
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (capture) begin
                        acc_q <= merged;
`ifdef ROM_PREFETCH_EN
                        if (redir_eff) begin
                            base_q <= tgt_base;
                            k_q    <= 2'd0;
                            acc_q  <= '0;
                        end else if (last) begin
                            k_q <= 2'd0;
                            if (!pf_own) begin
                                instr_data  <= merged;
                                instr_addr  <= base_q;
                                instr_valid <= 1'b1;
                            end
                        end else begin
                            k_q <= k_q + 2'd1;
                        end
`else
                        if (last) begin
                            k_q         <= 2'd0;
                            instr_data  <= merged;
                            instr_addr  <= base_q;
                            instr_valid <= 1'b1;
                        end else begin
                            k_q <= k_q + 2'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    if (consume) begin
                        instr_valid <= 1'b0;
`ifdef ROM_PREFETCH_EN
                        base_q <= base_q + 32'd4;
                        k_q    <= 2'd0;
                        acc_q  <= '0;
`endif
                    end
`ifdef ROM_PREFETCH_EN
                    // buffer hit: word was loaded at accept, valid follows one edge later
                    else if (!instr_valid) begin
                        instr_valid <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef ROM_PREFETCH_EN
    // Prefetch buffer bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_active_q  <= 1'b0;
            pf_valid_q   <= 1'b0;
            redir_q      <= 1'b0;
            pf_addr_q    <= '0;
            pf_data_q    <= '0;
            redir_base_q <= '0;
        end else if (flush) begin
            pf_active_q <= 1'b0;
            pf_valid_q  <= 1'b0;
            redir_q     <= 1'b0;
        end else begin
            if ((state_q == IDLE) && accept)
                pf_valid_q <= 1'b0;
            if (steal) begin
                pf_active_q <= 1'b0;
                if ((req_base != base_q) && !capture) begin
                    redir_q      <= 1'b1;
                    redir_base_q <= req_base;
                end
            end
            if (capture && redir_q)
                redir_q <= 1'b0;
            if (capture && last && pf_own && !redir_eff) begin
                pf_valid_q  <= 1'b1;
                pf_addr_q   <= base_q;
                pf_data_q   <= merged;
                pf_active_q <= 1'b0;
            end
            if (consume) begin
                pf_active_q <= 1'b1;
                pf_valid_q  <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed bench for rom_fetch. Two instances share one ROM
// image: [0] default parameters, [1] WAIT_CYCLES=3 with BIG_ENDIAN=1.
module tb_rom_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [31:0] req_addr    [2];
    logic        flush       [2];
    logic        instr_valid [2];
    logic        instr_ready [2];
    logic [31:0] instr_data  [2];
    logic [31:0] instr_addr  [2];
    logic [31:0] rom_addr    [2];
    logic        rom_trigger [2];
    logic [7:0]  rom_data    [2];

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    // ROM image
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h22;
            32'h0000_0102: return 8'h33;
            32'h0000_0103: return 8'h44;
            32'h0000_0200: return 8'hA1;
            32'h0000_0201: return 8'hB2;
            32'h0000_0202: return 8'hC3;
            32'h0000_0203: return 8'hD4;
            32'hFFFF_FFFC: return 8'h5A;
            32'hFFFF_FFFD: return 8'h6B;
            32'hFFFF_FFFE: return 8'h7C;
            32'hFFFF_FFFF: return 8'h8D;
            default:       return 8'hEE;
        endcase
    endfunction

    assign rom_data[0] = rom_byte(rom_addr[0]);
    assign rom_data[1] = rom_byte(rom_addr[1]);

    rom_fetch u_le (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .flush(flush[0]),
        .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
        .instr_data(instr_data[0]), .instr_addr(instr_addr[0]),
        .rom_addr(rom_addr[0]), .rom_trigger(rom_trigger[0]), .rom_data(rom_data[0])
    );

    rom_fetch #(.WAIT_CYCLES(3), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .flush(flush[1]),
        .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
        .instr_data(instr_data[1]), .instr_addr(instr_addr[1]),
        .rom_addr(rom_addr[1]), .rom_trigger(rom_trigger[1]), .rom_data(rom_data[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, follow the ROM sequence, check latency/addresses/word
    task automatic fetch(input int i, input logic [31:0] addr, input logic [31:0] base,
                         input int lat, input logic [31:0] word);
        int   edges;
        int   ntog;
        logic prev;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready[i]}, 32'd1);
        req_valid[i] = 1'b1;
        req_addr[i]  = addr;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        prev  = rom_trigger[i];
        edges = 0;
        ntog  = 0;
        while (!instr_valid[i] && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (rom_trigger[i] !== prev) begin
                chk("rom_addr", rom_addr[i], base + 32'(ntog));
                ntog++;
                prev = rom_trigger[i];
            end
        end
        chk("latency", 32'(edges), 32'(lat));
        chk("toggles", 32'(ntog), 32'd4);
        chk("instr_data", instr_data[i], word);
        chk("instr_addr", instr_addr[i], base);
    endtask

    // One cycle of instr_ready; block must return to IDLE
    task automatic consume(input int i);
        @(negedge clk);
        instr_ready[i] = 1'b1;
        @(posedge clk); #1;
        instr_ready[i] = 1'b0;
        chk("valid_cleared", {31'd0, instr_valid[i]}, 32'd0);
        chk("ready_after", {31'd0, req_ready[i]}, 32'd1);
    endtask

    initial begin
        logic t0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]   = 1'b0;
            req_addr[i]    = '0;
            flush[i]       = 1'b0;
            instr_ready[i] = 1'b0;
        end

        // reset state
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid",   {31'd0, instr_valid[i]}, 32'd0);
            chk("rst_data",    instr_data[i], 32'd0);
            chk("rst_iaddr",   instr_addr[i], 32'd0);
            chk("rst_romaddr", rom_addr[i], 32'd0);
            chk("rst_trig",    {31'd0, rom_trigger[i]}, 32'd0);
            chk("rst_ready",   {31'd0, req_ready[i]}, 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // little-endian fetch, then hold with instr_ready low
        fetch(0, 32'h0000_0100, 32'h0000_0100, 8, 32'h4433_2211);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, instr_valid[0]}, 32'd1);
            chk("hold_data",  instr_data[0], 32'h4433_2211);
            chk("hold_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        consume(0);

        // instr_ready with nothing valid is ignored
        @(negedge clk);
        instr_ready[0] = 1'b1;
        @(posedge clk); #1;
        instr_ready[0] = 1'b0;
        chk("stray_ready_valid", {31'd0, instr_valid[0]}, 32'd0);
        chk("stray_ready_idle",  {31'd0, req_ready[0]}, 32'd1);

        // flush during byte-2 WAIT with a request pending
        t0 = rom_trigger[0];
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0200;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush[0]     = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0300;
        #1 chk("flush_ready_wait", {31'd0, req_ready[0]}, 32'd0);
        @(posedge clk); #1;
        chk("flush_ready_idle", {31'd0, req_ready[0]}, 32'd0);
        chk("flush_valid",      {31'd0, instr_valid[0]}, 32'd0);
        @(posedge clk); #1;
        flush[0]     = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        chk("flush_not_accepted", {31'd0, req_ready[0]}, 32'd1);
        chk("flush_trig_level",   {31'd0, rom_trigger[0]}, {31'd0, ~t0});
        chk("flush_romaddr",      rom_addr[0], 32'h0000_0202);
        repeat (4) @(posedge clk); #1;
        chk("flush_no_valid", {31'd0, instr_valid[0]}, 32'd0);
        chk("flush_no_toggle", {31'd0, rom_trigger[0]}, {31'd0, ~t0});

        fetch(0, 32'h0000_0200, 32'h0000_0200, 8, 32'hD4C3_B2A1);
        consume(0);

        // big-endian, unaligned request address, WAIT_CYCLES=3
        fetch(1, 32'h0000_0103, 32'h0000_0100, 16, 32'h1122_3344);
        consume(1);

        // top-of-memory word
        fetch(1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 16, 32'h5A6B_7C8D);
        consume(1);

        // reset in the middle of a fetch
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0200;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_trig",    {31'd0, rom_trigger[0]}, 32'd0);
        chk("midrst_romaddr", rom_addr[0], 32'd0);
        chk("midrst_valid",   {31'd0, instr_valid[0]}, 32'd0);
        chk("midrst_ready",   {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(0, 32'h0000_0101, 32'h0000_0100, 8, 32'h4433_2211);
        consume(0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/rom_fetch.md
Name: rom_fetch

Overview:
- Initiator side of the byte-wide ROM read interface.
- Accepts a word fetch request from the core and drives the ROM with an address and a toggle-style trigger, four times in sequence.
- Samples each returned byte and assembles a 32-bit instruction word.
- Presents the word to the core through a valid/ready handshake. Sits between the core's fetch stage and the rom block.

Parameters:
WAIT_CYCLES, 1, clock edges between a trigger toggle and sampling rom_data (1..15)
BIG_ENDIAN, 0, 0: byte at base+0 lands in instr_data[7:0]; 1: it lands in [31:24]

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core fetch request valid
req_ready  output  1  fetcher can accept a request
req_addr  input  32  byte address of word; bits [1:0] forced to 0 internally
flush  input  1  abort any in-flight fetch, drop held word
instr_valid  output  1  instr_data/instr_addr valid
instr_ready  input  1  core consumes word
instr_data  output  32  assembled word
instr_addr  output  32  word-aligned address of instr_data
rom_addr  output  32  byte address to ROM
rom_trigger  output  1  toggles once per byte read; ROM responds on both edges
rom_data  input  8  byte returned by ROM

Behaviour:
- Reset values (async on rst_n low):
  - state=IDLE; rom_addr=0; rom_trigger=0.
  - instr_valid=0; instr_data=0; instr_addr=0; byte index=0; wait counter=0.
- req_ready = (state==IDLE) && !flush, combinational.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on req_valid&&req_ready, latch base={req_addr[31:2],2'b00}, k=0, go ISSUE.
- ISSUE, one cycle: at edge, rom_addr<=base+k, rom_trigger<=~rom_trigger, cnt<=WAIT_CYCLES, go WAIT.
- WAIT: cnt decrements each edge.
  - At the edge where cnt==1, capture rom_data into byte lane k per BIG_ENDIAN.
  - If k==3: go DONE, set instr_valid=1, instr_addr=base.
  - Otherwise: k<=k+1, go ISSUE.
- DONE: hold instr_data/instr_addr stable while instr_valid&&!instr_ready. On instr_ready, clear instr_valid and go IDLE. No new request is accepted in the same cycle.
- Latency: instr_valid rises 4*(1+WAIT_CYCLES) edges after the accept edge (8 for default).
- rom_trigger toggles exactly 4 times per fetch. Its level is never reset except by rst_n.
- Address arithmetic is 32-bit wrapping: base 0xFFFFFFFC reads bytes ...FC..FF. The next prefetch address wraps to 0x00000000.
- flush: has priority over every other event in the same cycle.
  - From any state, go IDLE next edge and clear instr_valid.
  - Partial bytes are discarded; rom_trigger is not toggled back.
  - A req_valid coinciding with flush is not accepted.
- flush during WAIT: the pending ROM response is ignored.
- rst_n asserted mid-fetch: immediate return to reset values.
- instr_ready while instr_valid=0: ignored.

Optional Feature:
- Macro ROM_PREFETCH_EN.
- Defined:
  - After a word is consumed in DONE, the block automatically fetches base+4 into a one-word prefetch buffer. req_ready stays high during this fetch.
  - On a request whose aligned address equals the buffered address and the buffer is complete, the block goes directly to DONE. instr_valid rises on the edge after accept.
  - On a mismatching request, the buffer is dropped; the in-progress ROM sequence completes its current byte and then restarts at the new address.
  - flush invalidates the buffer.
- Undefined: no buffer; behaviour is exactly as above.

Test Plan:
- Reset, then request 0x00000100 with ROM bytes 11,22,33,44 at 0x100..0x103 -> rom_trigger toggles 4 times; rom_addr 0x100..0x103; instr_valid rises 8 edges after accept; instr_data=0x44332211; instr_addr=0x100.
- Same with BIG_ENDIAN=1, req_addr=0x103 -> base 0x100; instr_data=0x11223344.
- Hold instr_ready=0 for 5 cycles -> instr_valid, instr_data, req_ready=0 stable; one cycle of instr_ready -> IDLE; req_ready=1 next cycle.
- Assert flush during the WAIT of byte 2 with req_valid high -> request not accepted that cycle; IDLE next edge; instr_valid never rises; a later fetch of 0x200 returns correct data.
- Request 0xFFFFFFFC with WAIT_CYCLES=3 -> rom_addr FC,FD,FE,FF; instr_valid 16 edges after accept.
- With ROM_PREFETCH_EN: fetch 0x100, consume, then request 0x104 -> instr_valid 1 edge after accept with the 0x104 word. Request 0x300 instead -> full refetch, correct data.
